// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a 1-cycle-latency synchronous instruction
// memory and presents {instr, instr_pc, instr_valid} to decode, with stall/hold.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] decode_pc_reg, decode_pc_next;
  logic        decode_valid_reg, decode_valid_next;
  logic [31:0] hold_instr_reg, hold_instr_next;

  logic [31:0] seq_pc;
  logic [31:0] target_pc;

  // Sequential PC wraps naturally at 2^32; redirect targets are word aligned.
  assign seq_pc    = fetch_pc_reg + 32'd4;
  assign target_pc = redirect ? {redirect_pc[31:2], 2'b00} : seq_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= BOOT;
      fetch_pc_reg     <= RESET_PC;
      decode_pc_reg    <= 32'h0;
      decode_valid_reg <= 1'b0;
      hold_instr_reg   <= NOP;
    end else begin
      state_reg        <= state_next;
      fetch_pc_reg     <= fetch_pc_next;
      decode_pc_reg    <= decode_pc_next;
      decode_valid_reg <= decode_valid_next;
      hold_instr_reg   <= hold_instr_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    fetch_pc_next     = fetch_pc_reg;
    decode_pc_next    = decode_pc_reg;
    decode_valid_next = decode_valid_reg;
    hold_instr_next   = hold_instr_reg;

    case (state_reg)
      BOOT: begin
        state_next        = RUN;
        decode_pc_next    = fetch_pc_reg;
        decode_valid_next = 1'b1;
        fetch_pc_next     = seq_pc;
      end
      RUN, HOLD: begin
        if (!stall) begin
          // Advance: redirect only steers F, so the instruction at F is the delay slot.
          state_next        = RUN;
          fetch_pc_next     = target_pc;
          decode_pc_next    = fetch_pc_reg;
          decode_valid_next = 1'b1;
        end else begin
          if (flush) begin
            decode_valid_next = 1'b0;
          end
          // Entering HOLD captures the memory word before imem_dout moves on to F.
          if (state_reg == RUN) begin
            state_next      = HOLD;
            hold_instr_next = (decode_valid_reg && !flush) ? imem_dout : NOP;
          end
        end
      end
      default: begin
        state_next        = BOOT;
        fetch_pc_next     = RESET_PC;
        decode_pc_next    = 32'h0;
        decode_valid_next = 1'b0;
        hold_instr_next   = NOP;
      end
    endcase
  end

  assign imem_addr   = fetch_pc_reg;
  assign instr_pc    = decode_pc_reg;
  assign instr_valid = decode_valid_reg;

  always_comb begin
    instr = NOP;
    if (decode_valid_reg) begin
      if (state_reg == HOLD) begin
        instr = hold_instr_reg;
      end else if (state_reg == RUN) begin
        instr = imem_dout;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a scoreboard of expected consumed
// instructions plus per-scenario inline checks of pc, data, address and valid.
module tb_fetch_stage;

  localparam logic [31:0] RP   = 32'h4000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0000;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  fetch_stage #(
    .RESET_PC(RP),
    .NOP     (NOPW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .flush      (flush),
    .imem_addr  (imem_addr),
    .imem_dout  (imem_dout),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: one-cycle latency, word = address ^ KEY.
  always @(posedge clk) imem_dout <= imem_addr ^ KEY;

  // Scoreboard: an instruction is consumed when valid and not stalled.
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, nothing expected", instr_pc, instr);
      end else begin
        exp_pc = sb_q.pop_front();
        if (instr_pc !== exp_pc || instr !== (exp_pc ^ KEY)) begin
          errors++;
          $display("FAIL sb_txn: got pc=%h instr=%h, want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, exp_pc ^ KEY);
        end else begin
          $display("txn pc=%h instr=%h", instr_pc, instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic f);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    flush       = f;
  endtask

  task automatic test_reset();
    next_cycle();
    checks++;
    if (imem_addr !== RP) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RP); end
    checks++;
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++;
    if (instr !== NOPW) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOPW); end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_boot_redirect();
    sb_q.push_back(RP);
    sb_q.push_back(RP + 32'h4);
    sb_q.push_back(RP + 32'h8);
    sb_q.push_back(RP + 32'hC);
    sb_q.push_back(RP + 32'h100);
    sb_q.push_back(RP + 32'h104);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP) begin
      errors++; $display("FAIL boot_first: got valid=%b pc=%h want 1 %h", instr_valid, instr_pc, RP);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (instr_pc !== RP + 32'h8) begin errors++; $display("FAIL pre_redirect_pc: got %h want %h", instr_pc, RP + 32'h8); end
    drive(1'b0, 1'b1, RP + 32'h103, 1'b0);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP + 32'hC) begin
      errors++; $display("FAIL delay_slot: got valid=%b pc=%h want 1 %h", instr_valid, instr_pc, RP + 32'hC);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_pc !== RP + 32'h100 || imem_addr !== RP + 32'h104) begin
      errors++; $display("FAIL redirect_target: got pc=%h addr=%h want %h %h", instr_pc, imem_addr, RP + 32'h100, RP + 32'h104);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    sb_q.push_back(RP + 32'h108);
    sb_q.push_back(RP + 32'h10);
    sb_q.push_back(RP + 32'h14);
    sb_q.push_back(RP + 32'h18);
    drive(1'b0, 1'b1, RP + 32'h10, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_pc !== RP + 32'h10) begin errors++; $display("FAIL pre_stall_pc: got %h want %h", instr_pc, RP + 32'h10); end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (instr_pc !== RP + 32'h10 || instr !== ((RP + 32'h10) ^ KEY) || instr_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h valid=%b want %h %h 1",
                           i, instr_pc, instr, instr_valid, RP + 32'h10, (RP + 32'h10) ^ KEY);
      end
      checks++;
      if (imem_addr !== RP + 32'h14) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, RP + 32'h14); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_pc !== RP + 32'h14 || instr !== ((RP + 32'h14) ^ KEY)) begin
      errors++; $display("FAIL stall_release: got pc=%h instr=%h want %h %h", instr_pc, instr, RP + 32'h14, (RP + 32'h14) ^ KEY);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    sb_q.push_back(RP + 32'h1C);
    sb_q.push_back(RP + 32'h20);
    sb_q.push_back(RP + 32'h28);
    next_cycle();
    next_cycle();
    checks++;
    if (instr_pc !== RP + 32'h20) begin errors++; $display("FAIL pre_flush_pc: got %h want %h", instr_pc, RP + 32'h20); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP + 32'h24) begin
      errors++; $display("FAIL flush_next_valid: got valid=%b pc=%h want 1 %h", instr_valid, instr_pc, RP + 32'h24);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOPW) begin
      errors++; $display("FAIL flush_stall: got valid=%b instr=%h want 0 %h", instr_valid, instr, NOPW);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOPW) begin
      errors++; $display("FAIL flush_hold: got valid=%b instr=%h want 0 %h", instr_valid, instr, NOPW);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP + 32'h28) begin
      errors++; $display("FAIL flush_release: got valid=%b pc=%h want 1 %h", instr_valid, instr_pc, RP + 32'h28);
    end
  endtask

  task automatic test_wrap_redirect_flush();
    sb_q.push_back(RP + 32'h2C);
    sb_q.push_back(32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP + 32'h2C || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL redir_flush: got valid=%b pc=%h addr=%h want 1 %h fffffffc",
                         instr_valid, instr_pc, imem_addr, RP + 32'h2C);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got pc=%h addr=%h want fffffffc 00000000", instr_pc, imem_addr);
    end
    next_cycle();
    checks++;
    if (instr_pc !== 32'h0 || instr !== KEY) begin
      errors++; $display("FAIL wrap_zero: got pc=%h instr=%h want 00000000 %h", instr_pc, instr, KEY);
    end
  endtask

  task automatic test_reset_mid_hold();
    sb_q.push_back(RP);
    sb_q.push_back(RP + 32'h4);
    sb_q.push_back(RP + 32'h8);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, RP + 32'h200, 1'b0);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr !== KEY) begin
      errors++; $display("FAIL hold_before_rst: got valid=%b instr=%h want 1 %h", instr_valid, instr, KEY);
    end
    drive(1'b1, 1'b1, RP + 32'h200, 1'b1);
    rst = 1'b1;
    next_cycle();
    checks++;
    if (imem_addr !== RP || instr_pc !== 32'h0 || instr_valid !== 1'b0 || instr !== NOPW) begin
      errors++; $display("FAIL rst_mid_hold: got addr=%h pc=%h valid=%b instr=%h want %h 0 0 %h",
                         imem_addr, instr_pc, instr_valid, instr, RP, NOPW);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RP || instr !== (RP ^ KEY)) begin
      errors++; $display("FAIL reboot_first: got valid=%b pc=%h instr=%h want 1 %h %h",
                         instr_valid, instr_pc, instr, RP, RP ^ KEY);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_boot_redirect();
    test_stall();
    test_flush();
    test_wrap_redirect_flush();
    test_reset_mid_hold();
    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high; the ports are named clk and rst.
REQ-002 Parameter RESET_PC, default 32'h4000_0000, SHALL be the first fetch address after reset.
REQ-003 Parameter NOP, default 32'h0000_0000, SHALL be the instruction word presented whenever instr_valid is 0.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port stall, input, 1 bit: downstream cannot accept a new instruction this cycle.
REQ-007 Port redirect, input, 1 bit: the branch/jump unit's next PC replaces the sequential PC.
REQ-008 Port redirect_pc, input, 32 bits: the target address (the NextPC from the branch/output selector).
REQ-009 Port flush, input, 1 bit: squash the instruction currently presented on instr.
REQ-010 Port imem_addr, output, 32 bits: byte address to the synchronous instruction memory, which has 1-cycle read latency.
REQ-011 Port imem_dout, input, 32 bits: instruction memory data for the address presented in the previous cycle.
REQ-012 Port instr, output, 32 bits: the instruction delivered to decode.
REQ-013 Port instr_pc, output, 32 bits: the address of instr (the oldPC consumed by the branch/output selector).
REQ-014 Port instr_valid, output, 1 bit: instr and instr_pc are meaningful.

Function
REQ-015 Internal registers: fetch_pc (F), decode_pc (D), decode_valid (V), hold_instr (H), and a state register with states BOOT, RUN and HOLD.
REQ-016 imem_addr SHALL equal F combinationally, so data for address F appears on imem_dout one cycle later, paired with D.
REQ-017 instr_pc SHALL equal D, and instr_valid SHALL equal V.
REQ-018 instr SHALL select its source as follows:
- H in state HOLD;
- imem_dout in state RUN;
- NOP whenever V=0, in any state.
REQ-019 BOOT state:
- Entered on every rst cycle.
- V=0 in BOOT.
- On the next clock edge, the state goes to RUN, D<=F, V<=1 and F<=F+4.
REQ-020 RUN with stall=0, F update: F<=redirect ? {redirect_pc[31:2],2'b00} : F+4.
REQ-021 RUN with stall=0, D and V update: D<=F, and V<=1.
REQ-022 Flush and delay slots:
- flush=1 SHALL apply only to the instruction presented this cycle; the next instruction is not squashed.
- Hence flush=1 with stall=0 SHALL leave V<=1 for the next instruction.
- redirect SHALL NOT squash anything; the instruction at F is the delay slot and proceeds.
- flush=1 with stall=1 SHALL clear V (V<=0) and leave F and D unchanged.
REQ-023 RUN to HOLD: when stall=1 in RUN, H<=imem_dout (or NOP if V=0), F and D SHALL hold, and the state SHALL go to HOLD.
REQ-024 HOLD with stall=1: F, D, V and H SHALL hold, and instr SHALL remain H.
REQ-025 HOLD with stall=0 (release): the same update as REQ-020 and REQ-021 SHALL occur, and the state SHALL go to RUN. During the HOLD cycles imem_addr stayed at F, so imem_dout in the following cycle is the instruction at the new D.
REQ-026 redirect SHALL be sampled only when stall=0. While stalled, downstream holds redirect and redirect_pc until release.
REQ-027 Address width rules:
- F+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
- redirect_pc bits [1:0] SHALL be ignored.
REQ-028 When redirect=1 and flush=1 occur in the same stall=0 cycle, both SHALL take effect.

Reset
REQ-029 During any cycle with rst=1, including mid-stall or mid-redirect, the next state SHALL be:
- F=RESET_PC;
- D=32'h0;
- V=0;
- H=NOP;
- state=BOOT.
REQ-030 Reset outputs: while in BOOT, imem_addr=RESET_PC, instr_pc=0, instr_valid=0 and instr=NOP.
REQ-031 rst SHALL take priority over stall, redirect and flush.

Verification
REQ-032 Reset then run: memory returns addr^32'hA5A5_0000 for each address; release rst and apply no stall for 4 cycles. Required response:
- instr_valid=0 in the first cycle;
- then instr_pc = 4000_0000, 4000_0004, 4000_0008;
- instr matches each address.
REQ-033 Redirect with delay slot: redirect=1, redirect_pc=32'h4000_0103 while instr_pc=4000_0008. Required response:
- next instr_pc=4000_000C (delay slot, valid);
- then 4000_0100 and 4000_0104.
REQ-034 Stall for 3 cycles at instr_pc=4000_0010. Required response:
- instr and instr_pc stable for all 3 cycles;
- imem_addr=4000_0014 throughout;
- after release, instr_pc=4000_0014 with the correct data.
REQ-035 Flush handling: flush=1 with stall=0 at instr_pc=4000_0020 leaves the next instruction 4000_0024 valid; flush=1 with stall=1 gives instr_valid=0 and instr=NOP.
REQ-036 Wrap-around: redirect_pc=32'hFFFF_FFFC. Required response: fetch order FFFF_FFFC, then 0000_0000.
REQ-037 Reset asserted mid-HOLD: the bench applies rst for 1 cycle. Required response: the BOOT sequence of REQ-032 restarts at 4000_0000, and stale H is never presented.
